// File: rtl/gpio_ctrl_pkg.sv
// Shared definitions for the GPIO pad configuration bank: per-channel field map and FSM encoding.
package gpio_ctrl_pkg;

  localparam int unsigned FLD_MGMT_EN   = 0;
  localparam int unsigned FLD_OE_OVR    = 1;
  localparam int unsigned FLD_IE        = 2;
  localparam int unsigned FLD_OE        = 3;
  localparam int unsigned FLD_SCHMITT   = 4;
  localparam int unsigned FLD_SLEW      = 5;
  localparam int unsigned FLD_PD        = 6;
  localparam int unsigned FLD_PU        = 7;
  localparam int unsigned FLD_DRIVE_LSB = 8;
  localparam int unsigned DRIVE_W       = 2;
  localparam int unsigned MIN_PCB       = 10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } bank_state_e;

  function automatic logic rise_edge(input logic cur, input logic dly);
    return cur & ~dly;
  endfunction

endpackage

// File: rtl/gpio_ctrl_channel.sv
// One pad's configuration register (reset to its default, loaded on commit) and its
// management/user output mux.
module gpio_ctrl_channel
  import gpio_ctrl_pkg::*;
#(
  parameter int unsigned PCB = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               commit,
  input  logic [PCB-1:0]     cfg_load,
  input  logic [PCB-1:0]     cfg_default,
  input  logic               mgmt_out,
  input  logic               mgmt_oeb,
  input  logic               user_out,
  input  logic               user_oeb,
  output logic [PCB-1:0]     cfg,
  output logic               pad_inen,
  output logic               pad_outen,
  output logic               pad_out,
  output logic               pad_slew,
  output logic               pad_schmitt,
  output logic               pad_pullup,
  output logic               pad_pulldown,
  output logic [DRIVE_W-1:0] pad_drive
);

  logic [PCB-1:0] cfg_d;
  logic [PCB-1:0] cfg_q;

  always_comb begin
    cfg_d = cfg_q;
    if (commit) begin
      cfg_d = cfg_load;
    end else begin
      cfg_d = cfg_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cfg_q <= cfg_default;
    end else begin
      cfg_q <= cfg_d;
    end
  end

  // Output-enable override wins over the mgmt/user selection.
  always_comb begin
    pad_outen = 1'b0;
    pad_out   = 1'b0;
    if (cfg_q[FLD_OE_OVR]) begin
      pad_outen = cfg_q[FLD_OE];
    end else if (cfg_q[FLD_MGMT_EN]) begin
      pad_outen = ~mgmt_oeb;
    end else begin
      pad_outen = ~user_oeb;
    end
    if (cfg_q[FLD_MGMT_EN]) begin
      pad_out = mgmt_out;
    end else begin
      pad_out = user_out;
    end
  end

  assign cfg          = cfg_q;
  assign pad_inen     = cfg_q[FLD_IE];
  assign pad_slew     = cfg_q[FLD_SLEW];
  assign pad_schmitt  = cfg_q[FLD_SCHMITT];
  assign pad_pullup   = cfg_q[FLD_PU];
  assign pad_pulldown = cfg_q[FLD_PD];
  assign pad_drive    = cfg_q[FLD_DRIVE_LSB +: DRIVE_W];

endmodule

// File: rtl/gpio_control_bank.sv
// Multi-channel GPIO pad configuration bank: serial chain, bit-count check, commit FSM.
// Optional config readback through the chain is enabled by defining GPIO_CTRL_READBACK_EN.
module gpio_control_bank
  import gpio_ctrl_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS  = 8,
  parameter int unsigned PAD_CTRL_BITS = 10
) (
  input  logic                                  serial_clock,
  input  logic                                  reset,
  input  logic [NUM_CHANNELS*PAD_CTRL_BITS-1:0] gpio_defaults,
  input  logic                                  serial_data_in,
  input  logic                                  serial_shift,
  input  logic                                  serial_load,
  input  logic                                  serial_capture,
  output logic                                  serial_data_out,
  output logic                                  load_done,
  output logic                                  load_error,
  output logic [NUM_CHANNELS-1:0]               mgmt_gpio_in,
  input  logic [NUM_CHANNELS-1:0]               mgmt_gpio_out,
  input  logic [NUM_CHANNELS-1:0]               mgmt_gpio_oeb,
  output logic [NUM_CHANNELS-1:0]               user_gpio_in,
  input  logic [NUM_CHANNELS-1:0]               user_gpio_out,
  input  logic [NUM_CHANNELS-1:0]               user_gpio_oeb,
  input  logic [NUM_CHANNELS-1:0]               pad_gpio_in,
  output logic [NUM_CHANNELS-1:0]               pad_gpio_inen,
  output logic [NUM_CHANNELS-1:0]               pad_gpio_outen,
  output logic [NUM_CHANNELS-1:0]               pad_gpio_out,
  output logic [NUM_CHANNELS-1:0]               pad_gpio_slew_sel,
  output logic [NUM_CHANNELS-1:0]               pad_gpio_schmitt_sel,
  output logic [NUM_CHANNELS-1:0]               pad_gpio_pullup_sel,
  output logic [NUM_CHANNELS-1:0]               pad_gpio_pulldown_sel,
  output logic [2*NUM_CHANNELS-1:0]             pad_gpio_drive_sel
);

  localparam int unsigned TOTAL = NUM_CHANNELS * PAD_CTRL_BITS;
  localparam int unsigned CW    = $clog2(TOTAL + 2);
  localparam logic [CW-1:0] TOTAL_CNT = CW'(TOTAL);
  localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};

  bank_state_e state_q, state_d;
  logic [TOTAL-1:0] shift_reg_q, shift_reg_d;
  logic [CW-1:0]    count_q, count_d;
  logic             load_dly_q, load_dly_d;
  logic             sdo_q, sdo_d;
  logic             load_done_q, load_done_d;
  logic             load_error_q, load_error_d;
  logic [TOTAL-1:0] cfg_flat;
  logic             load_edge, capture_edge, count_ok;
  logic             do_shift, do_reject, do_commit, do_capture;

  assign load_edge = rise_edge(serial_load, load_dly_q);
  assign count_ok  = (count_q == TOTAL_CNT);
  assign load_dly_d = serial_load;

`ifdef GPIO_CTRL_READBACK_EN
  logic capture_dly_q, capture_dly_d;
  assign capture_dly_d = serial_capture;
  assign capture_edge  = rise_edge(serial_capture, capture_dly_q);

  always_ff @(posedge serial_clock) begin
    if (reset) begin
      capture_dly_q <= 1'b0;
    end else begin
      capture_dly_q <= capture_dly_d;
    end
  end
`else
  logic unused_readback;
  assign unused_readback = serial_capture ^ (^cfg_flat);
  assign capture_edge    = 1'b0;
`endif

  always_ff @(posedge serial_clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_SHIFT: begin
        if (load_edge) begin
          state_d = count_ok ? ST_COMMIT : ST_IDLE;
        end else if (do_shift) begin
          state_d = ST_SHIFT;
        end else begin
          state_d = state_q;
        end
      end
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // A load edge is judged on the pre-shift count; a shift in the same cycle is dropped.
  always_comb begin
    do_shift   = 1'b0;
    do_reject  = 1'b0;
    do_commit  = 1'b0;
    do_capture = 1'b0;
    case (state_q)
      ST_IDLE, ST_SHIFT: begin
        if (load_edge) begin
          do_reject = ~count_ok;
        end else if (capture_edge && (state_q == ST_IDLE)) begin
          do_capture = 1'b1;
        end else if (serial_shift) begin
          do_shift = 1'b1;
        end else begin
          do_shift = 1'b0;
        end
      end
      ST_COMMIT: do_commit = 1'b1;
      default:   do_commit = 1'b0;
    endcase
  end

  always_comb begin
    shift_reg_d  = shift_reg_q;
    count_d      = count_q;
    load_done_d  = 1'b0;
    load_error_d = load_error_q;
    if (do_commit) begin
      load_done_d  = 1'b1;
      load_error_d = 1'b0;
      count_d      = {CW{1'b0}};
    end else if (do_reject) begin
      load_error_d = 1'b1;
      count_d      = {CW{1'b0}};
    end else if (do_capture) begin
      shift_reg_d = cfg_flat;
      count_d     = {CW{1'b0}};
    end else if (do_shift) begin
      shift_reg_d = {shift_reg_q[TOTAL-2:0], serial_data_in};
      count_d     = (count_q == CNT_MAX) ? count_q : count_q + CNT_ONE;
    end else begin
      shift_reg_d = shift_reg_q;
    end
    sdo_d = shift_reg_d[TOTAL-1];
  end

  always_ff @(posedge serial_clock) begin
    if (reset) begin
      shift_reg_q  <= {TOTAL{1'b0}};
      count_q      <= {CW{1'b0}};
      load_dly_q   <= 1'b0;
      sdo_q        <= 1'b0;
      load_done_q  <= 1'b0;
      load_error_q <= 1'b0;
    end else begin
      shift_reg_q  <= shift_reg_d;
      count_q      <= count_d;
      load_dly_q   <= load_dly_d;
      sdo_q        <= sdo_d;
      load_done_q  <= load_done_d;
      load_error_q <= load_error_d;
    end
  end

  assign serial_data_out = sdo_q;
  assign load_done       = load_done_q;
  assign load_error      = load_error_q;
  assign mgmt_gpio_in    = pad_gpio_in;
  assign user_gpio_in    = pad_gpio_in;

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
    gpio_ctrl_channel #(.PCB(PAD_CTRL_BITS)) u_ch (
      .clk          (serial_clock),
      .reset        (reset),
      .commit       (do_commit),
      .cfg_load     (shift_reg_q[c*PAD_CTRL_BITS +: PAD_CTRL_BITS]),
      .cfg_default  (gpio_defaults[c*PAD_CTRL_BITS +: PAD_CTRL_BITS]),
      .mgmt_out     (mgmt_gpio_out[c]),
      .mgmt_oeb     (mgmt_gpio_oeb[c]),
      .user_out     (user_gpio_out[c]),
      .user_oeb     (user_gpio_oeb[c]),
      .cfg          (cfg_flat[c*PAD_CTRL_BITS +: PAD_CTRL_BITS]),
      .pad_inen     (pad_gpio_inen[c]),
      .pad_outen    (pad_gpio_outen[c]),
      .pad_out      (pad_gpio_out[c]),
      .pad_slew     (pad_gpio_slew_sel[c]),
      .pad_schmitt  (pad_gpio_schmitt_sel[c]),
      .pad_pullup   (pad_gpio_pullup_sel[c]),
      .pad_pulldown (pad_gpio_pulldown_sel[c]),
      .pad_drive    (pad_gpio_drive_sel[2*c +: 2])
    );
  end

endmodule

// File: tb/tb_gpio_control_bank.sv
// Directed self-checking bench for gpio_control_bank (2 channels x 10 bits).
module tb_gpio_control_bank;

  localparam int NCH = 2;
  localparam int PCB = 10;

  logic serial_clock = 1'b0;
  always #5 serial_clock = ~serial_clock;

  logic              reset;
  logic [19:0]       gpio_defaults;
  logic              serial_data_in, serial_shift, serial_load, serial_capture;
  logic              serial_data_out, load_done, load_error;
  logic [NCH-1:0]    mgmt_gpio_in, mgmt_gpio_out, mgmt_gpio_oeb;
  logic [NCH-1:0]    user_gpio_in, user_gpio_out, user_gpio_oeb;
  logic [NCH-1:0]    pad_gpio_in, pad_gpio_inen, pad_gpio_outen, pad_gpio_out;
  logic [NCH-1:0]    pad_gpio_slew_sel, pad_gpio_schmitt_sel, pad_gpio_pullup_sel, pad_gpio_pulldown_sel;
  logic [2*NCH-1:0]  pad_gpio_drive_sel;
  logic [17:0]       pads_obs;

  int tests_run    = 0;
  int tests_failed = 0;
  int pulses;
  logic [19:0] cfg_exp;
  logic [39:0] pat;

  gpio_control_bank #(.NUM_CHANNELS(NCH), .PAD_CTRL_BITS(PCB)) dut (
    .serial_clock          (serial_clock),
    .reset                 (reset),
    .gpio_defaults         (gpio_defaults),
    .serial_data_in        (serial_data_in),
    .serial_shift          (serial_shift),
    .serial_load           (serial_load),
    .serial_capture        (serial_capture),
    .serial_data_out       (serial_data_out),
    .load_done             (load_done),
    .load_error            (load_error),
    .mgmt_gpio_in          (mgmt_gpio_in),
    .mgmt_gpio_out         (mgmt_gpio_out),
    .mgmt_gpio_oeb         (mgmt_gpio_oeb),
    .user_gpio_in          (user_gpio_in),
    .user_gpio_out         (user_gpio_out),
    .user_gpio_oeb         (user_gpio_oeb),
    .pad_gpio_in           (pad_gpio_in),
    .pad_gpio_inen         (pad_gpio_inen),
    .pad_gpio_outen        (pad_gpio_outen),
    .pad_gpio_out          (pad_gpio_out),
    .pad_gpio_slew_sel     (pad_gpio_slew_sel),
    .pad_gpio_schmitt_sel  (pad_gpio_schmitt_sel),
    .pad_gpio_pullup_sel   (pad_gpio_pullup_sel),
    .pad_gpio_pulldown_sel (pad_gpio_pulldown_sel),
    .pad_gpio_drive_sel    (pad_gpio_drive_sel)
  );

  assign pads_obs = {pad_gpio_drive_sel, pad_gpio_pulldown_sel, pad_gpio_pullup_sel,
                     pad_gpio_schmitt_sel, pad_gpio_slew_sel, pad_gpio_out,
                     pad_gpio_outen, pad_gpio_inen};

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected pad controls for a 20-bit config image and the current mux inputs.
  function automatic logic [17:0] model_pads(input logic [19:0] cfg);
    logic [1:0] inen, outen, outv, slew, sch, pu, pd;
    logic [3:0] drv;
    logic [9:0] f;
    for (int c = 0; c < 2; c++) begin
      f         = cfg[c*10 +: 10];
      inen[c]   = f[2];
      outen[c]  = f[1] ? f[3] : (f[0] ? ~mgmt_gpio_oeb[c] : ~user_gpio_oeb[c]);
      outv[c]   = f[0] ? mgmt_gpio_out[c] : user_gpio_out[c];
      sch[c]    = f[4];
      slew[c]   = f[5];
      pd[c]     = f[6];
      pu[c]     = f[7];
      drv[c*2 +: 2] = f[9:8];
    end
    return {drv, pd, pu, sch, slew, outv, outen, inen};
  endfunction

  task automatic tick();
    @(posedge serial_clock);
    #1;
  endtask

  task automatic shift_bits(input logic [39:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      serial_shift   = 1'b1;
      serial_data_in = v[i];
      tick();
    end
    serial_shift   = 1'b0;
    serial_data_in = 1'b0;
  endtask

  task automatic pulse_load(input logic with_shift, output int n_done);
    serial_load    = 1'b1;
    serial_shift   = with_shift;
    serial_data_in = 1'b1;
    n_done = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      serial_shift   = 1'b0;
      serial_data_in = 1'b0;
      if (load_done) n_done++;
    end
    serial_load = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    reset = 1'b1;
    gpio_defaults  = 20'h00403;
    serial_data_in = 1'b0;
    serial_shift   = 1'b0;
    serial_load    = 1'b0;
    serial_capture = 1'b0;
    mgmt_gpio_out  = 2'b01;
    mgmt_gpio_oeb  = 2'b10;
    user_gpio_out  = 2'b10;
    user_gpio_oeb  = 2'b01;
    pad_gpio_in    = 2'b10;
    tick(); tick(); tick();
    reset = 1'b0;
    tick();

    // Reset state
    cfg_exp = 20'h00403;
    check_val("rst_load_done", {31'd0, load_done}, 32'd0);
    check_val("rst_load_error", {31'd0, load_error}, 32'd0);
    check_val("rst_sdo", {31'd0, serial_data_out}, 32'd0);
    check_val("rst_pads", {14'd0, pads_obs}, {14'd0, model_pads(cfg_exp)});
    check_val("rst_ch0_fields", {29'd0, pad_gpio_inen[0], pad_gpio_outen[0], pad_gpio_out[0]},
              {29'd0, 3'b001});
    check_val("gpio_in_copy", {28'd0, mgmt_gpio_in, user_gpio_in}, {28'd0, 4'b1010});

    // Good 20-bit load
    shift_bits(40'h00000A5C3F, 20);
    pulse_load(1'b0, pulses);
    cfg_exp = 20'hA5C3F;
    check_val("good_done_pulses", pulses, 32'd1);
    check_val("good_error", {31'd0, load_error}, 32'd0);
    check_val("good_pads", {14'd0, pads_obs}, {14'd0, model_pads(cfg_exp)});

    // Short load rejected, then a good one clears the error
    shift_bits(40'h00000F0F0, 19);
    pulse_load(1'b0, pulses);
    check_val("short_done_pulses", pulses, 32'd0);
    check_val("short_error", {31'd0, load_error}, 32'd1);
    check_val("short_pads_kept", {14'd0, pads_obs}, {14'd0, model_pads(cfg_exp)});
    shift_bits(40'h000005A3C6, 20);
    pulse_load(1'b0, pulses);
    cfg_exp = 20'h5A3C6;
    check_val("recover_done_pulses", pulses, 32'd1);
    check_val("recover_error", {31'd0, load_error}, 32'd0);
    check_val("recover_pads", {14'd0, pads_obs}, {14'd0, model_pads(cfg_exp)});

    // Load edge with a simultaneous shift uses the pre-shift count
    shift_bits(40'h0000012345, 19);
    pulse_load(1'b1, pulses);
    check_val("ls19_error", {31'd0, load_error}, 32'd1);
    check_val("ls19_pads_kept", {14'd0, pads_obs}, {14'd0, model_pads(cfg_exp)});
    shift_bits(40'h000003C96B, 20);
    pulse_load(1'b1, pulses);
    cfg_exp = 20'h3C96B;
    check_val("ls20_done_pulses", pulses, 32'd1);
    check_val("ls20_error", {31'd0, load_error}, 32'd0);
    check_val("ls20_pads", {14'd0, pads_obs}, {14'd0, model_pads(cfg_exp)});

    // 40-bit stream: chain latency, then saturated count rejects the load
    pat = 40'hC396A51E7B;
    for (int j = 0; j < 40; j++) begin
      serial_shift   = 1'b1;
      serial_data_in = pat[39-j];
      tick();
      if (j >= 19 && j <= 38)
        check_val($sformatf("chain_bit%0d", j - 19), {31'd0, serial_data_out}, {31'd0, pat[58-j]});
    end
    serial_shift = 1'b0;
    pulse_load(1'b0, pulses);
    check_val("sat_done_pulses", pulses, 32'd0);
    check_val("sat_error", {31'd0, load_error}, 32'd1);
    check_val("sat_pads_kept", {14'd0, pads_obs}, {14'd0, model_pads(cfg_exp)});

    // Reset mid-shift restores defaults and clears the count
    shift_bits(40'h00000003FF, 10);
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick();
    cfg_exp = 20'h00403;
    check_val("midrst_pads", {14'd0, pads_obs}, {14'd0, model_pads(cfg_exp)});
    check_val("midrst_error", {31'd0, load_error}, 32'd0);
    shift_bits(40'h0000012345, 20);
    pulse_load(1'b0, pulses);
    cfg_exp = 20'h12345;
    check_val("postrst_done_pulses", pulses, 32'd1);
    check_val("postrst_error", {31'd0, load_error}, 32'd0);
    check_val("postrst_pads", {14'd0, pads_obs}, {14'd0, model_pads(cfg_exp)});

    // ch0 now mgmt_en=1, oe_ovr=0: outen from mgmt oeb, out follows mgmt data
    mgmt_gpio_oeb = 2'b00;
    mgmt_gpio_out = 2'b00;
    #1;
    check_val("mux_outen0", {31'd0, pad_gpio_outen[0]}, 32'd1);
    check_val("mux_out0_lo", {31'd0, pad_gpio_out[0]}, 32'd0);
    mgmt_gpio_out = 2'b01;
    #1;
    check_val("mux_out0_hi", {31'd0, pad_gpio_out[0]}, 32'd1);
    user_gpio_oeb = 2'b11;
    #1;
    check_val("mux_pads", {14'd0, pads_obs}, {14'd0, model_pads(cfg_exp)});

`ifdef GPIO_CTRL_READBACK_EN
    serial_capture = 1'b1;
    tick();
    serial_capture = 1'b0;
    for (int k = 0; k < 20; k++) begin
      check_val($sformatf("readback_bit%0d", 19 - k), {31'd0, serial_data_out},
                {31'd0, cfg_exp[19-k]});
      shift_bits(40'd0, 1);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
